rf_alu_sequencer: RTL and testbench
===================================

Name: rf_alu_sequencer

Overview:
- Multi-cycle issue controller that drives the RF_ALU control interface: Read1, Read2, WriteReg, RegWrite, ALUOp and OpcodeField. It consumes the zero flag.
- Accepts one 32-bit LEGv8 R-format instruction per valid/ready handshake. Decodes it and sequences register read, ALU execute and register write-back.
- Reports completion, the zero flag and an illegal-opcode indication.
- Sits between the instruction source (bench or future fetch unit) and RF_ALU. It replaces hand-driven control.

Parameters:
- INSTR_W, 32, instruction width; fixed LEGv8 field layout.
- OPCODE_W, 11, width of OpcodeField, instr[31:21].
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, width of retire counter (optional feature only).

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- instr  in  INSTR_W  instruction word. Fields: opcode[31:21], Rm[20:16], shamt[15:10], Rn[9:5], Rd[4:0].
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- zero  in  1  zero flag from RF_ALU.
- ALUOp  out  2  ALU operation class to RF_ALU.
- OpcodeField  out  OPCODE_W  opcode to RF_ALU.
- Read1  out  REG_ADDR_W  = Rn.
- Read2  out  REG_ADDR_W  = Rm.
- WriteReg  out  REG_ADDR_W  = Rd.
- RegWrite  out  1  register-file write enable.
- done  out  1  one-cycle completion pulse.
- zero_flag  out  1  zero captured for the last instruction.
- illegal  out  1  last instruction had an unsupported opcode.
- retire_count  out  CNT_W  committed-instruction count.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - instr_ready=1.
  - ALUOp=0, OpcodeField=0, Read1=0, Read2=0, WriteReg=0.
  - RegWrite=0, done=0, zero_flag=0, illegal=0, retire_count=0.
  - Reset mid-instruction drops RegWrite immediately and discards the instruction; no partial write-back.
- States: IDLE -> DECODE -> EXEC -> WRITE -> DONE -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid && instr_ready, latch instr and go to DECODE. instr_ready falls next cycle.
  - instr_valid without ready is held off; instr must stay stable until accepted.
- DECODE:
  - Drive Read1=Rn, Read2=Rm, WriteReg=Rd, OpcodeField=opcode, ALUOp=2'b10.
  - Legal opcodes: AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000.
  - Legal -> EXEC.
  - Illegal -> DONE with illegal=1, ALUOp=0, no EXEC/WRITE; zero_flag unchanged.
- EXEC:
  - Hold all operand outputs.
  - Sample zero into zero_flag at the end of this cycle (one full cycle for RF_ALU settle).
- WRITE:
  - RegWrite=1 for exactly one cycle if Rd != 31; RF_ALU writes at the following rising edge.
  - Rd == 31 (XZR): RegWrite stays 0. The instruction still counts as committed.
- DONE:
  - done=1 for one cycle, then IDLE with instr_ready=1.
  - illegal holds until the next accept, where it clears.
  - zero_flag holds until overwritten.
- Timing:
  - Latency accept-to-done: 4 cycles legal, 2 cycles illegal.
  - Throughput: one instruction per 5 cycles (legal).
- Operand outputs hold their last values in IDLE/DONE; they do not return to 0.
- shamt is ignored.

Optional Feature:
- Macro: RF_ALU_SEQ_RETIRE_CNT_EN.
- Defined:
  - retire_count increments by 1 on each DONE of a legal instruction, including Rd=31.
  - Illegal instructions do not increment it.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared only by reset.
- Undefined: retire_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset: hold reset_n=0 mid-WRITE -> RegWrite=0 immediately, state IDLE, instr_ready=1, all outputs at reset values.
- ADD X3,X1,X2 = 0x8B020023, valid for one accept:
  - next cycle: Read1=1, Read2=2, WriteReg=3, OpcodeField=10001011000, ALUOp=10.
  - RegWrite=1 on cycle 3 only; done on cycle 4; illegal=0.
- SUB X4,X5,X5 = 0xCB0500A4 -> zero=1 sampled in EXEC, zero_flag=1 at done, RegWrite pulses with WriteReg=4.
- Illegal 0xFFFFFFFF -> done 2 cycles after accept, illegal=1, RegWrite never asserted, zero_flag unchanged, retire_count unchanged.
- AND X31,X1,X2 = 0x8A02003F -> full 4-cycle sequence, RegWrite stays 0, done=1; with RF_ALU_SEQ_RETIRE_CNT_EN, retire_count +1.
- Back-to-back: instr_valid held high with ORR then ADD -> second accepted only when instr_ready returns the cycle after done. No overlap; exactly one RegWrite pulse each.

Source files
------------

// File: rtl/rf_alu_sequencer.sv
// ---------------------------------------------------------------------------
// rf_alu_sequencer
//
// Multi-cycle issue controller for the RF_ALU block. It accepts one 32-bit
// LEGv8 R-format instruction per valid/ready handshake and walks it through
// the following states:
//   IDLE -> DECODE -> EXEC -> WRITE -> DONE -> IDLE
// The DECODE state goes straight to DONE when the opcode is not supported.
//
// Ports
//   clock         in   rising-edge system clock
//   reset_n       in   asynchronous active-low reset
//   instr         in   instruction word: opcode[31:21] Rm[20:16] shamt[15:10]
//                      Rn[9:5] Rd[4:0]; shamt is ignored
//   instr_valid   in   instruction offered
//   instr_ready   out  sequencer can accept (high only in IDLE)
//   zero          in   zero flag from RF_ALU, sampled at the end of EXEC
//   ALUOp         out  ALU operation class (2'b10 for R-format)
//   OpcodeField   out  opcode to RF_ALU
//   Read1/Read2   out  Rn / Rm register addresses
//   WriteReg      out  Rd register address
//   RegWrite      out  one-cycle write enable in WRITE (suppressed for XZR)
//   done          out  one-cycle completion pulse
//   zero_flag     out  zero captured for the last executed instruction
//   illegal       out  last instruction had an unsupported opcode
//   retire_count  out  committed-instruction count
//
// Optional feature: define RF_ALU_SEQ_RETIRE_CNT_EN to build the retire
// counter. Without the macro, retire_count is tied to zero.
//
// All outputs are registered. The operand outputs keep their last values
// through DONE and IDLE.
// ---------------------------------------------------------------------------
module rf_alu_sequencer #(
  parameter int INSTR_W    = 32,
  parameter int OPCODE_W   = 11,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  zero,
  output logic [1:0]            ALUOp,
  output logic [OPCODE_W-1:0]   OpcodeField,
  output logic [REG_ADDR_W-1:0] Read1,
  output logic [REG_ADDR_W-1:0] Read2,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic                  RegWrite,
  output logic                  done,
  output logic                  zero_flag,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retire_count
);

  localparam logic [OPCODE_W-1:0]   OP_AND = 11'b10001010000;
  localparam logic [OPCODE_W-1:0]   OP_ORR = 11'b10101010000;
  localparam logic [OPCODE_W-1:0]   OP_ADD = 11'b10001011000;
  localparam logic [OPCODE_W-1:0]   OP_SUB = 11'b11001011000;
  localparam logic [REG_ADDR_W-1:0] XZR    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;

  // Fixed LEGv8 R-format field positions.
  logic [OPCODE_W-1:0]   w_opcode;
  logic [REG_ADDR_W-1:0] w_rm;
  logic [REG_ADDR_W-1:0] w_rn;
  logic [REG_ADDR_W-1:0] w_rd;
  logic                  w_unused_shamt;

  assign w_opcode       = instr[31:21];
  assign w_rm           = instr[20:16];
  assign w_rn           = instr[9:5];
  assign w_rd           = instr[4:0];
  assign w_unused_shamt = ^instr[15:10];

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_AND) || (op == OP_ORR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // The operand outputs are loaded at the accept edge. They are therefore
  // valid throughout DECODE. Legality is judged from the registered
  // OpcodeField, so the sequencer needs no separate instruction latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      instr_ready <= 1'b1;
      ALUOp       <= '0;
      OpcodeField <= '0;
      Read1       <= '0;
      Read2       <= '0;
      WriteReg    <= '0;
      RegWrite    <= 1'b0;
      done        <= 1'b0;
      zero_flag   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            Read1       <= w_rn;
            Read2       <= w_rm;
            WriteReg    <= w_rd;
            OpcodeField <= w_opcode;
            ALUOp       <= 2'b10;
            illegal     <= 1'b0;
            instr_ready <= 1'b0;
            r_state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal(OpcodeField)) begin
            r_state <= S_EXEC;
          end else begin
            // An unsupported opcode skips execute and write-back entirely.
            ALUOp   <= 2'b00;
            illegal <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_EXEC: begin
          // RF_ALU has had the whole EXEC cycle to settle. The write enable
          // is raised here so that it is high exactly during WRITE.
          zero_flag <= zero;
          RegWrite  <= (WriteReg != XZR);
          r_state   <= S_WRITE;
        end
        S_WRITE: begin
          RegWrite <= 1'b0;
          done     <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          RegWrite    <= 1'b0;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RF_ALU_SEQ_RETIRE_CNT_EN
  // Only legal instructions reach WRITE, so counting WRITE->DONE
  // transitions counts commits. XZR destinations are included. The
  // updated value is visible together with the done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retire_count <= '0;
    end else if (r_state == S_WRITE) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end
`else
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_rf_alu_sequencer.sv
module tb_rf_alu_sequencer;

  logic        clock;
  logic        reset_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero;
  logic [1:0]  ALUOp;
  logic [10:0] OpcodeField;
  logic [4:0]  Read1, Read2, WriteReg;
  logic        RegWrite, done, zero_flag, illegal;
  logic [15:0] retire_count;

  rf_alu_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .zero         (zero),
    .ALUOp        (ALUOp),
    .OpcodeField  (OpcodeField),
    .Read1        (Read1),
    .Read2        (Read2),
    .WriteReg     (WriteReg),
    .RegWrite     (RegWrite),
    .done         (done),
    .zero_flag    (zero_flag),
    .illegal      (illegal),
    .retire_count (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [10:0] op;
    logic [4:0]  rn, rm, rd;
    logic        ill;
    logic        zf;
    int          n_rw;
    int          lat;
    logic [15:0] rc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_rc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The monitor observes accepts, counts the RegWrite pulses, and checks
  // each completion against the scoreboard.
  logic        busy = 1'b0;
  int          cyc, rw_n, rw_cyc;
  logic [4:0]  rw_reg;

  always @(negedge clock) begin
    if (!reset_n) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        cyc++;
        if (RegWrite) begin
          rw_n++;
          rw_reg = WriteReg;
          rw_cyc = cyc;
        end
        if (cyc == 1 && sb.size() > 0) begin
          chk("decode_Read1",    32'(Read1),       32'(sb[0].rn));
          chk("decode_Read2",    32'(Read2),       32'(sb[0].rm));
          chk("decode_WriteReg", 32'(WriteReg),    32'(sb[0].rd));
          chk("decode_Opcode",   32'(OpcodeField), 32'(sb[0].op));
          chk("decode_ALUOp",    32'(ALUOp),       32'd2);
          chk("decode_ready",    32'(instr_ready), 32'd0);
        end
        if (done) begin
          if (sb.size() == 0) begin
            chk("done_without_expectation", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency",        32'(cyc),          32'(e.lat));
            chk("illegal",        32'(illegal),      32'(e.ill));
            chk("zero_flag",      32'(zero_flag),    32'(e.zf));
            chk("regwrite_count", 32'(rw_n),         32'(e.n_rw));
            chk("done_ALUOp",     32'(ALUOp),        e.ill ? 32'd0 : 32'd2);
            chk("done_WriteReg",  32'(WriteReg),     32'(e.rd));
            chk("retire_count",   32'(retire_count), 32'(e.rc));
            if (rw_n > 0) begin
              chk("regwrite_reg",   32'(rw_reg), 32'(e.rd));
              chk("regwrite_cycle", 32'(rw_cyc), 32'd3);
            end
          end
          busy = 1'b0;
        end
      end else begin
        if (RegWrite) chk("regwrite_while_idle", 32'd1, 32'd0);
        if (done)     chk("done_while_idle", 32'd1, 32'd0);
      end
      if (instr_valid && instr_ready) begin
        busy = 1'b1;
        cyc  = 0;
        rw_n = 0;
      end
    end
  end

  // This task issues one instruction and pushes its expectation. It returns
  // #1 after the accept edge, and acc_t is the time of that accept edge.
  task automatic send(input logic [31:0] ins, input logic z,
                      input logic [10:0] op, input logic [4:0] rn, rm, rd,
                      input logic ill, input logic zf, input int n_rw,
                      input int lat, input logic hold, output time acc_t);
    exp_t e;
    logic acc;
`ifdef RF_ALU_SEQ_RETIRE_CNT_EN
    if (!ill) exp_rc = exp_rc + 16'd1;
`endif
    e.op = op; e.rn = rn; e.rm = rm; e.rd = rd;
    e.ill = ill; e.zf = zf; e.n_rw = n_rw; e.lat = lat; e.rc = exp_rc;
    sb.push_back(e);
    instr       = ins;
    instr_valid = 1'b1;
    zero        = z;
    acc         = 1'b0;
    acc_t       = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = instr_ready;
      @(posedge clock);
      acc_t = $time;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},    32'(instr_ready),  32'd1);
    chk({tag, "_ALUOp"},    32'(ALUOp),        32'd0);
    chk({tag, "_Opcode"},   32'(OpcodeField),  32'd0);
    chk({tag, "_Read1"},    32'(Read1),        32'd0);
    chk({tag, "_Read2"},    32'(Read2),        32'd0);
    chk({tag, "_WriteReg"}, 32'(WriteReg),     32'd0);
    chk({tag, "_RegWrite"}, 32'(RegWrite),     32'd0);
    chk({tag, "_done"},     32'(done),         32'd0);
    chk({tag, "_zflag"},    32'(zero_flag),    32'd0);
    chk({tag, "_illegal"},  32'(illegal),      32'd0);
    chk({tag, "_retire"},   32'(retire_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    time t0, t1, t2;
    int  n;
    reset_n     = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    zero        = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("por");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // ADD X3,X1,X2
    send(32'h8B020023, 1'b0, 11'b10001011000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1, 4, 1'b0, t0);
    wait_drain();
    // SUB X4,X5,X5 with zero=1
    send(32'hCB0500A4, 1'b1, 11'b11001011000, 5'd5, 5'd5, 5'd4, 1'b0, 1'b1, 1, 4, 1'b0, t0);
    wait_drain();
    // An illegal opcode must leave zero_flag at 1 even though zero is now 0.
    send(32'hFFFFFFFF, 1'b0, 11'h7FF, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 0, 2, 1'b0, t0);
    wait_drain();
    chk("illegal_holds", 32'(illegal), 32'd1);
    // AND X31,X1,X2: destination XZR, no write, still committed
    send(32'h8A02003F, 1'b0, 11'b10001010000, 5'd1, 5'd2, 5'd31, 1'b0, 1'b0, 0, 4, 1'b0, t0);
    wait_drain();

    // Back-to-back: instr_valid stays high. ORR X5,X6,X7 is followed by ADD X8,X9,X10.
    send(32'hAA0700C5, 1'b0, 11'b10101010000, 5'd6, 5'd7, 5'd5, 1'b0, 1'b0, 1, 4, 1'b1, t1);
    send(32'h8B0A0128, 1'b0, 11'b10001011000, 5'd9, 5'd10, 5'd8, 1'b0, 1'b0, 1, 4, 1'b0, t2);
    chk("b2b_accept_gap", 32'((t2 - t1) / 10), 32'd5);
    wait_drain();

    // Reset asserted while in WRITE
    send(32'h8B020023, 1'b1, 11'b10001011000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1, 4, 1'b0, t0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!RegWrite && n < 10);
    chk("reach_write", 32'(RegWrite), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midwrite");
    sb.delete();
    if (exp_rc != 16'd0) exp_rc = exp_rc - 16'd1;
    repeat (2) @(negedge clock);
    chk_reset_vals("held");
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_RegWrite", 32'(RegWrite), 32'd0);
    chk("post_reset_done",     32'(done),     32'd0);
    chk("post_reset_ready",    32'(instr_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
